// File: rtl/gpv_ack_responder_if.sv
// Request/ack bundle between a gpv requester (master) and the ack responder (slave).
interface gpv_ack_responder_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]        valid_i;
  logic [NUM_CH*DATA_W-1:0] data_i;
  logic [NUM_CH-1:0]        ack_o;
  logic [DATA_W-1:0]        data_o;
  logic                     data_vld_o;
  logic [CH_W-1:0]          ch_o;
  logic [15:0]              txn_cnt_o;
  logic                     err_o;

  modport master (
    output valid_i, data_i,
    input  ack_o, data_o, data_vld_o, ch_o, txn_cnt_o, err_o
  );

  modport slave (
    input  valid_i, data_i,
    output ack_o, data_o, data_vld_o, ch_o, txn_cnt_o, err_o
  );
endinterface

// File: rtl/gpv_ack_responder.sv
// Multi-channel valid/ack responder with programmable wait and round-robin ack arbitration.
// Optional sticky protocol-error reporting is enabled by defining GPV_ACK_RSP_ERR_EN.
module gpv_ack_responder #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 4,
  parameter int MODE      = 0,
  parameter int FIXED_DLY = 2
) (
  input logic                clk_i,
  input logic                rstn_i,
  gpv_ack_responder_if.slave bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] TGT_RST = (MODE == 1) ? CNT_W'(FIXED_DLY) : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REQ  = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t           state_r     [NUM_CH];
  state_t           state_nxt_s [NUM_CH];
  logic [CNT_W-1:0] cnt_r       [NUM_CH];
  logic [CNT_W-1:0] cnt_nxt_s   [NUM_CH];
  logic [CNT_W-1:0] tgt_r       [NUM_CH];
  logic [CNT_W-1:0] tgt_nxt_s   [NUM_CH];

  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] gnt_vec_s;
  logic              gnt_any_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [DATA_W-1:0] gnt_data_s;
  logic [CH_W-1:0]   ptr_r;
  int                best_d_s;

  logic [NUM_CH-1:0] ack_r, ack_nxt_s;
  logic [DATA_W-1:0] data_r, data_nxt_s;
  logic              vld_r, vld_nxt_s;
  logic [CH_W-1:0]   ch_r, ch_nxt_s;
  logic [15:0]       txn_r, txn_nxt_s;

  // Round-robin arbiter: the requester closest to the pointer (cyclically) wins.
  always_comb begin
    gnt_any_s  = 1'b0;
    gnt_idx_s  = {CH_W{1'b0}};
    gnt_data_s = {DATA_W{1'b0}};
    best_d_s   = NUM_CH;
    for (int c = 0; c < NUM_CH; c++) begin
      req_s[c] = (state_r[c] == ST_REQ) && bus.valid_i[c];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (req_s[c] && (((c + NUM_CH - int'(ptr_r)) % NUM_CH) < best_d_s)) begin
        best_d_s  = (c + NUM_CH - int'(ptr_r)) % NUM_CH;
        gnt_idx_s = CH_W'(c);
        gnt_any_s = 1'b1;
      end else begin
        best_d_s  = best_d_s;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      gnt_vec_s[c] = gnt_any_s && (gnt_idx_s == CH_W'(c));
      if (gnt_vec_s[c]) begin
        gnt_data_s = bus.data_i[c*DATA_W +: DATA_W];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
  end

  // Per-channel next-state, wait counter and wait target.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_nxt_s[c] = state_r[c];
      cnt_nxt_s[c]   = cnt_r[c];
      tgt_nxt_s[c]   = tgt_r[c];
      case (state_r[c])
        ST_IDLE: begin
          if (!bus.valid_i[c]) begin
            state_nxt_s[c] = ST_IDLE;
          end else if (tgt_r[c] == {CNT_W{1'b0}}) begin
            state_nxt_s[c] = ST_REQ;
          end else begin
            state_nxt_s[c] = ST_WAIT;
            cnt_nxt_s[c]   = CNT_W'(1);
          end
        end
        ST_WAIT: begin
          // A dropped valid abandons the transaction and keeps the target.
          if (!bus.valid_i[c]) begin
            state_nxt_s[c] = ST_IDLE;
            cnt_nxt_s[c]   = {CNT_W{1'b0}};
          end else if (cnt_r[c] == tgt_r[c]) begin
            state_nxt_s[c] = ST_REQ;
          end else begin
            cnt_nxt_s[c]   = cnt_r[c] + CNT_W'(1);
          end
        end
        ST_REQ: begin
          if (!bus.valid_i[c]) begin
            state_nxt_s[c] = ST_IDLE;
            cnt_nxt_s[c]   = {CNT_W{1'b0}};
          end else if (gnt_vec_s[c]) begin
            state_nxt_s[c] = ST_ACK;
          end else begin
            state_nxt_s[c] = ST_REQ;
          end
        end
        ST_ACK: begin
          state_nxt_s[c] = ST_IDLE;
          cnt_nxt_s[c]   = {CNT_W{1'b0}};
          if (MODE == 0) begin
            tgt_nxt_s[c] = tgt_r[c] + CNT_W'(1);
          end else begin
            tgt_nxt_s[c] = tgt_r[c];
          end
        end
        default: begin
          state_nxt_s[c] = ST_IDLE;
          cnt_nxt_s[c]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Channel state registers and arbitration pointer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c] <= ST_IDLE;
        cnt_r[c]   <= {CNT_W{1'b0}};
        tgt_r[c]   <= TGT_RST;
      end
      ptr_r <= {CH_W{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c] <= state_nxt_s[c];
        cnt_r[c]   <= cnt_nxt_s[c];
        tgt_r[c]   <= tgt_nxt_s[c];
      end
      if (gnt_any_s) begin
        ptr_r <= (gnt_idx_s == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : gnt_idx_s + CH_W'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Next values of the shared outputs; they hold when nothing is granted.
  always_comb begin
    ack_nxt_s = gnt_vec_s;
    vld_nxt_s = gnt_any_s;
    if (gnt_any_s) begin
      data_nxt_s = gnt_data_s;
      ch_nxt_s   = gnt_idx_s;
      txn_nxt_s  = txn_r + 16'd1;
    end else begin
      data_nxt_s = data_r;
      ch_nxt_s   = ch_r;
      txn_nxt_s  = txn_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_r  <= {NUM_CH{1'b0}};
      data_r <= {DATA_W{1'b0}};
      vld_r  <= 1'b0;
      ch_r   <= {CH_W{1'b0}};
      txn_r  <= 16'd0;
    end else begin
      ack_r  <= ack_nxt_s;
      data_r <= data_nxt_s;
      vld_r  <= vld_nxt_s;
      ch_r   <= ch_nxt_s;
      txn_r  <= txn_nxt_s;
    end
  end

  assign bus.ack_o      = ack_r;
  assign bus.data_o     = data_r;
  assign bus.data_vld_o = vld_r;
  assign bus.ch_o       = ch_r;
  assign bus.txn_cnt_o  = txn_r;

`ifdef GPV_ACK_RSP_ERR_EN
  logic [NUM_CH-1:0] drop_s;
  logic              err_r;
  logic [NUM_CH-1:0] err_vec_r;

  // Valid falling while waiting or requesting is a protocol violation.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      drop_s[c] = ((state_r[c] == ST_WAIT) || (state_r[c] == ST_REQ)) && !bus.valid_i[c];
    end
  end

  // Sticky error flag and per-channel error record.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_r     <= 1'b0;
      err_vec_r <= {NUM_CH{1'b0}};
    end else begin
      err_r     <= err_r | (|drop_s);
      err_vec_r <= err_vec_r | drop_s;
    end
  end

  assign bus.err_o = err_r;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpv_ack_responder.sv
// Randomized scoreboard bench for gpv_ack_responder (MODE 0, CNT_W 2, four channels).
module tb_gpv_ack_responder;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 32;
  localparam int CNT_W     = 2;
  localparam int MODE      = 0;
  localparam int FIXED_DLY = 2;
  localparam int CH_W      = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  gpv_ack_responder_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) bus ();

  gpv_ack_responder #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .MODE(MODE), .FIXED_DLY(FIXED_DLY)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  typedef struct {
    int                edge_no;
    int                ch;
    logic [DATA_W-1:0] data;
    logic [15:0]       txn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Transaction-level reference: each channel is either free (from some edge on) or busy
  // since a start edge; it may be granted once start + target + 1 edges have passed.
  int          edge_n = 0;
  bit          m_active [NUM_CH];
  int          m_start  [NUM_CH];
  int          m_free   [NUM_CH];
  int          m_tgt    [NUM_CH];
  int          m_ptr;
  logic [15:0] m_txn;
  bit          m_drop_seen;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_active[c] = 1'b0;
      m_free[c]   = 0;
      m_tgt[c]    = (MODE == 1) ? FIXED_DLY : 0;
    end
    m_ptr       = 0;
    m_txn       = 16'd0;
    m_drop_seen = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input int e);
    bit   req [NUM_CH];
    int   g;
    exp_t it;
    g = -1;
    for (int c = 0; c < NUM_CH; c++) begin
      req[c] = 1'b0;
      if (m_active[c]) begin
        if (!bus.valid_i[c]) begin
          m_active[c] = 1'b0;
          m_free[c]   = e + 1;
          m_drop_seen = 1'b1;
        end else if (e >= m_start[c] + m_tgt[c] + 1) begin
          req[c] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (g < 0 && req[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
    end
    if (g >= 0) begin
      m_active[g] = 1'b0;
      m_free[g]   = e + 2;
      m_txn       = m_txn + 16'd1;
      m_ptr       = (g + 1) % NUM_CH;
      if (MODE == 0) m_tgt[g] = (m_tgt[g] + 1) % (1 << CNT_W);
      it.edge_no = e;
      it.ch      = g;
      it.data    = bus.data_i[g*DATA_W +: DATA_W];
      it.txn     = m_txn;
      exp_q.push_back(it);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!m_active[c] && e >= m_free[c] && bus.valid_i[c]) begin
        m_active[c] = 1'b1;
        m_start[c]  = e;
      end
    end
  endtask

  task automatic monitor_step();
    exp_t              it;
    logic [NUM_CH-1:0] exp_ack;
    if (bus.data_vld_o) begin
      check(exp_q.size() > 0, "unexpected_ack",
            $sformatf("edge %0d ch_o=%0d got ack, model expected none", edge_n, bus.ch_o));
      if (exp_q.size() > 0) begin
        it      = exp_q.pop_front();
        exp_ack = '0;
        exp_ack[it.ch] = 1'b1;
        check(it.edge_no == edge_n && bus.ch_o == it.ch && bus.data_o == it.data &&
              bus.txn_cnt_o == it.txn && bus.ack_o == exp_ack, "ack_txn",
              $sformatf("edge %0d ch=%0d data=%h txn=%0d ack=%b, required edge %0d ch=%0d data=%h txn=%0d ack=%b",
                        edge_n, bus.ch_o, bus.data_o, bus.txn_cnt_o, bus.ack_o,
                        it.edge_no, it.ch, it.data, it.txn, exp_ack));
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_n) begin
      it = exp_q.pop_front();
      check(bus.data_vld_o == 1'b1, "missing_ack",
            $sformatf("edge %0d no ack, required ch=%0d at edge %0d", edge_n, it.ch, it.edge_no));
    end else begin
      check(bus.ack_o == '0, "idle_ack", $sformatf("edge %0d ack=%b, required 0", edge_n, bus.ack_o));
    end
  endtask

  // Reference model advances on every rising edge using the stimulus the DUT sees.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rstn) model_reset();
      else begin
        edge_n++;
        model_step(edge_n);
      end
    end
  end

  // Scoreboard monitor samples DUT outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) monitor_step();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic single_txn(input int exp_lat, input string name);
    int s, n;
    bit seen;
    @(negedge clk);
    bus.valid_i[0] = 1'b1;
    bus.data_i[DATA_W-1:0] = $urandom;
    s    = edge_n + 1;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.ack_o[0]) begin
        seen = 1'b1;
        check(edge_n - s == exp_lat, name, $sformatf("latency %0d, required %0d", edge_n - s, exp_lat));
      end
    end
    if (!seen) check(seen, name, "no ack within 40 cycles");
    bus.valid_i[0] = 1'b0;
  endtask

  int lat_tab [6] = '{1, 2, 3, 4, 1, 2};

  initial begin
    int  s, n, tmo;
    bit  exp_err;
    bus.valid_i = '0;
    bus.data_i  = '0;
    rstn        = 1'b0;
    repeat (3) @(negedge clk);
    check(bus.ack_o == '0 && bus.data_o == '0 && !bus.data_vld_o && bus.ch_o == '0 &&
          bus.txn_cnt_o == 16'd0 && !bus.err_o, "reset_state",
          $sformatf("ack=%b data=%h vld=%b ch=%0d txn=%0d err=%b, required all 0",
                    bus.ack_o, bus.data_o, bus.data_vld_o, bus.ch_o, bus.txn_cnt_o, bus.err_o));
    rstn = 1'b1;

    // Channel 0 with valid held high: wait target walks 0,1,2,3 then wraps.
    @(negedge clk);
    bus.valid_i[0] = 1'b1;
    bus.data_i[DATA_W-1:0] = $urandom;
    s = edge_n + 1;
    n = 0;
    tmo = 0;
    while (n < 6 && tmo < 200) begin
      @(negedge clk);
      tmo++;
      if (bus.ack_o[0]) begin
        check(edge_n - s == lat_tab[n], "latency_inc",
              $sformatf("txn %0d latency %0d, required %0d", n, edge_n - s, lat_tab[n]));
        s = edge_n + 2;
        n++;
      end
    end
    check(n == 6, "phase_a_acks", $sformatf("%0d acks, required 6", n));
    bus.valid_i[0] = 1'b0;
    check(bus.txn_cnt_o == 16'd6, "txn_cnt_6", $sformatf("txn_cnt %0d, required 6", bus.txn_cnt_o));
    check(bus.err_o == 1'b0, "err_clean", $sformatf("err %b, required 0", bus.err_o));

    // One more transaction (target 2) leaves channel 0 with target 3.
    single_txn(3, "latency_tgt2");
    repeat (2) @(negedge clk);
    bus.valid_i[0] = 1'b1;
    bus.data_i[DATA_W-1:0] = $urandom;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check(bus.ack_o == '0 && bus.data_o == '0 && !bus.data_vld_o && bus.ch_o == '0 &&
          bus.txn_cnt_o == 16'd0 && !bus.err_o, "reset_async",
          $sformatf("ack=%b data=%h vld=%b ch=%0d txn=%0d err=%b, required all 0",
                    bus.ack_o, bus.data_o, bus.data_vld_o, bus.ch_o, bus.txn_cnt_o, bus.err_o));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bus.valid_i[0] = 1'b0;
    single_txn(1, "latency_after_reset");

    // Random multi-channel traffic with contention, back-to-back and protocol drops.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (!bus.valid_i[c]) begin
          if ($urandom_range(2) == 0) begin
            bus.valid_i[c] = 1'b1;
            bus.data_i[c*DATA_W +: DATA_W] = $urandom;
          end
        end else if (bus.ack_o[c]) begin
          if ($urandom_range(1) == 0) bus.valid_i[c] = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          bus.valid_i[c] = 1'b0;
        end
      end
    end
    bus.valid_i = '0;
    repeat (20) @(negedge clk);
    check(exp_q.size() == 0, "queue_drained", $sformatf("%0d expected acks outstanding, required 0", exp_q.size()));
`ifdef GPV_ACK_RSP_ERR_EN
    exp_err = m_drop_seen;
`else
    exp_err = 1'b0;
`endif
    check(bus.err_o == exp_err, "err_final", $sformatf("err %b, required %b", bus.err_o, exp_err));
    check(bus.txn_cnt_o == m_txn, "txn_final", $sformatf("txn_cnt %0d, required %0d", bus.txn_cnt_o, m_txn));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
